// File: rtl/sram_b_reader.sv
// ---------------------------------------------------------------------------
// sram_b_reader
//
// Read-side initiator for the operand-B scratchpad SRAM (1-cycle registered
// read). A burst command (base, length-1, optional stride) is turned into at
// most one SRAM read per cycle. The returned bytes are collected in a
// 2-entry buffer and presented as a valid/ready byte stream to the MAC array,
// with out_last flagging the final beat of the burst.
//
// Optional feature macro: SRAM_B_READER_STRIDE_EN
//   defined   : the address step is the latched cmd_stride (mod 2^AW)
//   undefined : cmd_stride is ignored, the address step is 1
//
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   cmd_valid/ready command handshake; cmd_ready only high in IDLE
//   cmd_base        first address of the burst
//   cmd_len_m1      burst length minus one
//   cmd_stride      per-beat address increment (feature builds only)
//   busy            burst in progress (RUN or DRAIN)
//   sram_ce/we      SRAM chip enable / write enable (we tied low)
//   sram_addr       SRAM address, holds its last value while ce is low
//   sram_din        SRAM write data (tied low)
//   sram_dout       SRAM read data, valid the cycle after ce
//   out_valid/ready downstream byte stream handshake
//   out_data        stream byte
//   out_last        final beat of the burst, qualified by out_valid
// ---------------------------------------------------------------------------
module sram_b_reader #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len_m1,
  input  logic [AW-1:0] cmd_stride,
  output logic          busy,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Occupancy limit expressed in the width of the occupancy arithmetic.
  localparam logic [2:0] DEPTH_LIMIT = 3'(FIFO_DEPTH);

  state_e          state_q;
  logic [AW-1:0]   len_m1_q;
  logic [AW-1:0]   issue_addr_q;
  logic [AW-1:0]   last_addr_q;
  // One bit wider than the address so a 2^AW-beat burst can be counted.
  logic [AW:0]     issue_cnt_q;
  logic [AW-1:0]   cap_cnt_q;
  logic            inflight_q;

  // Output buffer: two entries, a 1-bit pointer each side, 0..2 count.
  logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic            fifo_last_q [FIFO_DEPTH];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic            last_tag;
  logic [2:0]      occ_d;
  logic [AW-1:0]   step;

`ifdef SRAM_B_READER_STRIDE_EN
  logic [AW-1:0]   stride_q;
  assign step = stride_q;
`else
  // Stride is not part of this build; fold it into a sink so it is not
  // mistaken for a forgotten connection.
  logic            unused_stride;
  assign unused_stride = ^cmd_stride;
  assign step          = AW'(1);
`endif

  // ---------------------------------------------------------------------
  // Stream side
  // ---------------------------------------------------------------------
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;

  // The registered read returns the byte one cycle after ce.
  assign push      = inflight_q;
  // cap_cnt_q numbers the returning reads; the one numbered len_m1 is last.
  assign last_tag  = (cap_cnt_q == len_m1_q);

  // Occupancy the buffer would have after this edge if nothing new were
  // issued. Issuing is only allowed while that still leaves room for the
  // byte coming back next cycle, so the buffer can never overflow even
  // when the consumer stalls indefinitely.
  assign occ_d = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue = (state_q == ST_RUN)
               & (issue_cnt_q <= {1'b0, len_m1_q})
               & (occ_d < DEPTH_LIMIT);

  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  // ---------------------------------------------------------------------
  // SRAM side
  // ---------------------------------------------------------------------
  assign sram_ce   = issue;
  assign sram_we   = 1'b0;
  assign sram_din  = '0;
  // Present the live issue address only when reading, otherwise keep the
  // previously issued address on the bus.
  assign sram_addr = issue ? issue_addr_q : last_addr_q;

  // ---------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------
  assign cmd_ready = rst_n & (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------
  // Sequencer, capture and buffer state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_m1_q     <= '0;
      issue_addr_q <= '0;
      last_addr_q  <= '0;
      issue_cnt_q  <= '0;
      cap_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
`ifdef SRAM_B_READER_STRIDE_EN
      stride_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_m1_q     <= cmd_len_m1;
            issue_addr_q <= cmd_base;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
`ifdef SRAM_B_READER_STRIDE_EN
            stride_q     <= cmd_stride;
`endif
            state_q      <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (issue) begin
            // Natural AW-bit wrap gives the modulo-2^AW address walk.
            issue_addr_q <= issue_addr_q + step;
            last_addr_q  <= issue_addr_q;
            issue_cnt_q  <= issue_cnt_q + 1'b1;
            // Leave on the edge that issues the final read.
            if (issue_cnt_q[AW-1:0] == len_m1_q) begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (pop && out_last) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      inflight_q <= issue;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= sram_dout;
        fifo_last_q[wr_ptr_q] <= last_tag;
        wr_ptr_q              <= ~wr_ptr_q;
        cap_cnt_q             <= cap_cnt_q + 1'b1;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      count_q <= count_d;
    end
  end

  // A push into a full buffer without a simultaneous pop would lose data.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count_q == 2'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_sram_b_reader.sv
module tb_sram_b_reader;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_len_m1;
  logic [AW-1:0] cmd_stride;
  logic          busy;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  int n_cmp = 0;
  int n_err = 0;

  // backpressure scenario bookkeeping
  int            fcnt;
  int            infl;
  int            issued;
  int            beats;
  int            pop_i;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  // SRAM model: mem[i] = i[7:0], registered read.
  always @(posedge clk) begin
    if (sram_ce) sram_dout <= sram_addr[7:0];
  end

  sram_b_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len_m1 (cmd_len_m1),
    .cmd_stride (cmd_stride),
    .busy       (busy),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one burst with out_ready held high and check every cycle until
  // the block is back in IDLE. With hold set, cmd_valid stays asserted and
  // the command fields are changed mid-burst (they must be ignored).
  task automatic burst(input logic [AW-1:0] base, input logic [AW-1:0] len,
                       input logic [AW-1:0] stride, input bit hold);
    logic [AW-1:0] step;
    logic [AW-1:0] a;
    int            lasts;
`ifdef SRAM_B_READER_STRIDE_EN
    step = stride;
`else
    step = 10'd1;
`endif
    cmd_base   = base;
    cmd_len_m1 = len;
    cmd_stride = stride;
    cmd_valid  = 1'b1;
    out_ready  = 1'b1;
    lasts      = 0;
    for (int k = 1; k <= int'(len) + 4; k++) begin
      tick();
      if (k == 1 && !hold) cmd_valid = 1'b0;
      if (k == 2 && hold) begin
        cmd_base   = 10'h055;
        cmd_len_m1 = 10'd0;
      end
      chk("busy", 32'(busy), 32'(k <= int'(len) + 3));
      chk("cmd_ready", 32'(cmd_ready), 32'(k == int'(len) + 4));
      chk("sram_ce", 32'(sram_ce), 32'(k <= int'(len) + 1));
      if (k <= int'(len) + 1) begin
        a = 10'(int'(base) + (k - 1) * int'(step));
        chk("sram_addr", 32'(sram_addr), 32'(a));
      end
      chk("out_valid", 32'(out_valid), 32'(k >= 3 && k <= int'(len) + 3));
      if (k >= 3 && k <= int'(len) + 3) begin
        a = 10'(int'(base) + (k - 3) * int'(step));
        chk("out_data", 32'(out_data), 32'(a[7:0]));
        chk("out_last", 32'(out_last), 32'(k == int'(len) + 3));
        if (out_last) lasts++;
      end
    end
    chk("last_count", 32'(lasts), 32'd1);
  endtask

  initial begin
    // ---------------- reset ----------------
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_len_m1 = '0;
    cmd_stride = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sram_ce", 32'(sram_ce), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("step: reset checked");

    // ---------------- basic burst ----------------
    burst(10'h010, 10'd3, 10'd0, 1'b0);
    $display("step: burst base=0x010 len_m1=3");

    // ---------------- address wrap ----------------
    burst(10'h3FE, 10'd3, 10'd0, 1'b0);
    $display("step: burst base=0x3FE len_m1=3 (wrap)");

    // ---------------- backpressure ----------------
    cmd_base   = 10'h020;
    cmd_len_m1 = 10'd7;
    cmd_valid  = 1'b1;
    out_ready  = 1'b1;
    fcnt       = 0;
    infl       = 0;
    issued     = 0;
    beats      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 80 && beats < 8; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      out_ready = ((c % 3) == 0);
      #1;
      pop_i = (out_valid && out_ready) ? 1 : 0;
      chk("bp_valid", 32'(out_valid), 32'(fcnt != 0));
      if (sram_ce) begin
        chk("bp_room", 32'((fcnt + infl - pop_i) < 2), 32'd1);
        chk("bp_addr", 32'(sram_addr), 32'(10'h020 + 10'(issued)));
        issued++;
      end
      if (prev_stall && out_valid) chk("bp_hold", 32'(out_data), 32'(prev_data));
      if (pop_i == 1) begin
        chk("bp_data", 32'(out_data), 32'(8'h20 + 8'(beats)));
        chk("bp_last", 32'(out_last), 32'(beats == 7));
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      fcnt       = fcnt + infl - pop_i;
      infl       = sram_ce ? 1 : 0;
    end
    chk("bp_beats", 32'(beats), 32'd8);
    chk("bp_issued", 32'(issued), 32'd8);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    $display("step: backpressure burst base=0x020 len_m1=7, %0d beats", beats);

    // ---------------- reset mid-burst ----------------
    cmd_base   = 10'h000;
    cmd_len_m1 = 10'd15;
    cmd_valid  = 1'b1;
    out_ready  = 1'b1;
    tick();                                   // C1
    cmd_valid = 1'b0;
    tick();                                   // C2
    tick();                                   // C3
    chk("mr_beat0", 32'(out_data), 32'h00);
    tick();                                   // C4
    chk("mr_beat1", 32'(out_data), 32'h01);
    tick();                                   // C5
    chk("mr_beat2", 32'(out_data), 32'h02);
    chk("mr_valid2", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_ready_in_rst", 32'(cmd_ready), 32'd0);
    tick();                                   // after reset edge
    rst_n = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_sram_ce", 32'(sram_ce), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_out_last", 32'(out_last), 32'd0);
    burst(10'h100, 10'd0, 10'd0, 1'b0);
    $display("step: reset mid-burst, then base=0x100 len_m1=0");

    // ---------------- stride (or unit step) ----------------
    burst(10'h004, 10'd4, 10'h100, 1'b0);
    $display("step: burst base=0x004 stride=0x100 len_m1=4");

    // ---------------- full-length burst, cmd_valid held ----------------
    burst(10'h000, 10'd1023, 10'd0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("held_accept_busy", 32'(busy), 32'd1);
    chk("held_accept_ce", 32'(sram_ce), 32'd1);
    chk("held_accept_addr", 32'(sram_addr), 32'h055);
    tick();
    chk("held_valid_c2", 32'(out_valid), 32'd0);
    tick();
    chk("held_valid_c3", 32'(out_valid), 32'd1);
    chk("held_data", 32'(out_data), 32'h55);
    chk("held_last", 32'(out_last), 32'd1);
    tick();
    chk("held_idle_busy", 32'(busy), 32'd0);
    chk("held_idle_ready", 32'(cmd_ready), 32'd1);
    $display("step: 1024-beat burst with cmd_valid held, then held command");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
